// File: rtl/cpu_controller_if.sv
// cpu_controller_if: instruction-in / datapath-control-out bundle between sequencer and datapath
interface cpu_controller_if #(
    parameter int CNT_W = 16
);
    logic             s;
    logic [2:0]       opcode;
    logic [1:0]       op;
    logic             w;
    logic [2:0]       nsel;
    logic [1:0]       vsel;
    logic             loada;
    logic             loadb;
    logic             loadc;
    logic             loads;
    logic             asel;
    logic             bsel;
    logic             write;
    logic [1:0]       alu_op;
    logic             halted;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output s, opcode, op,
        input  w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, alu_op, halted, instr_cnt
    );

    modport slave (
        input  s, opcode, op,
        output w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write, alu_op, halted, instr_cnt
    );
endinterface

// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing one datapath instruction per start pulse; HALT opcode enabled by `define CTRL_HALT_EN
module cpu_controller #(
    parameter logic [2:0] OPC_MOV  = 3'b110,
    parameter logic [2:0] OPC_ALU  = 3'b101,
    parameter logic [2:0] OPC_HALT = 3'b111,
    parameter int         CNT_W    = 16
) (
    input logic             clk,
    input logic             reset,
    cpu_controller_if.slave bus
);
    typedef enum logic [3:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WR_REG, S_IMM, S_WR_IMM, S_HALT
    } state_t;

    state_t           state, nxt, halt_tgt;
    logic [2:0]       opc_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_movi, is_movr, is_alu, is_mvn, is_cmp, retire;

    assign is_movi       = (opc_q == OPC_MOV) && (op_q == 2'b10);
    assign is_movr       = (opc_q == OPC_MOV) && (op_q == 2'b00);
    assign is_alu        = (opc_q == OPC_ALU);
    assign is_mvn        = is_alu && (op_q == 2'b11);
    assign is_cmp        = is_alu && (op_q == 2'b01);
    assign bus.instr_cnt = cnt_q;

`ifdef CTRL_HALT_EN
    assign halt_tgt   = S_HALT;
    assign bus.halted = (state == S_HALT);
`else
    assign halt_tgt   = S_WAIT;
    assign bus.halted = 1'b0;
`endif

    // state register; the instruction fields are captured only when a start is accepted in WAIT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
            opc_q <= '0;
            op_q  <= '0;
        end else begin
            state <= nxt;
            if (state == S_WAIT && bus.s) begin
                opc_q <= bus.opcode;
                op_q  <= bus.op;
            end
        end
    end

    // retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else if (retire)
            cnt_q <= cnt_q + 1'b1;
    end

    // next state and Moore outputs; MOV# spends one idle cycle in S_IMM before the write
    always_comb begin
        nxt        = state;
        retire     = 1'b0;
        bus.w      = 1'b0;
        bus.nsel   = 3'b000;
        bus.vsel   = 2'b00;
        bus.loada  = 1'b0;
        bus.loadb  = 1'b0;
        bus.loadc  = 1'b0;
        bus.loads  = 1'b0;
        bus.asel   = 1'b0;
        bus.bsel   = 1'b0;
        bus.write  = 1'b0;
        bus.alu_op = is_alu ? op_q : 2'b00;
        case (state)
            S_WAIT: begin
                bus.w = 1'b1;
                nxt   = bus.s ? S_DECODE : S_WAIT;
            end
            S_DECODE: begin
                nxt    = is_movi ? S_IMM :
                         (is_movr || is_mvn) ? S_GET_B :
                         is_alu ? S_GET_A :
                         (opc_q == OPC_HALT) ? halt_tgt : S_WAIT;
                retire = (nxt == S_HALT);
            end
            S_GET_A: begin
                bus.nsel  = 3'b001;
                bus.loada = 1'b1;
                nxt       = S_GET_B;
            end
            S_GET_B: begin
                bus.nsel  = 3'b100;
                bus.loadb = 1'b1;
                nxt       = S_EXEC;
            end
            S_EXEC: begin
                bus.asel  = is_movr;
                bus.loads = is_cmp;
                bus.loadc = !is_cmp;
                nxt       = is_cmp ? S_WAIT : S_WR_REG;
                retire    = is_cmp;
            end
            S_WR_REG: begin
                bus.nsel  = 3'b010;
                bus.write = 1'b1;
                nxt       = S_WAIT;
                retire    = 1'b1;
            end
            S_IMM: nxt = S_WR_IMM;
            S_WR_IMM: begin
                bus.nsel  = 3'b001;
                bus.vsel  = 2'b10;
                bus.write = 1'b1;
                nxt       = S_WAIT;
                retire    = 1'b1;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_WAIT;
        endcase
    end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed vector table plus reset, back-to-back and HALT sequences
module tb_cpu_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    int   t_cyc, t_a, t_b, t_c, t_s, t_w, t_as, t_bad;
    logic [1:0] t_alu, t_vs;

    always #5 clk = ~clk;

    cpu_controller_if #(.CNT_W(16)) bus ();
    cpu_controller #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic [2:0] opc;
        logic [1:0] op;
        int         cyc, inc, na, nb, nc, ns, nw, nas;
        logic [1:0] alu, vs;
        string      name;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // called at a negedge while the DUT is in WAIT; returns at the negedge where w is back
    task automatic issue(input logic [2:0] opc, input logic [1:0] op, input bit hold);
        bus.opcode = opc;
        bus.op     = op;
        bus.s      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.s = 1'b0;
        bus.opcode = ~opc;
        bus.op     = ~op;
        t_cyc = 0; t_a = 0; t_b = 0; t_c = 0; t_s = 0; t_w = 0; t_as = 0; t_bad = 0;
        t_alu = 2'b00; t_vs = 2'b00;
        while (!bus.w && t_cyc < 30) begin
            if (bus.loada) begin t_a++; if (bus.nsel != 3'b001) t_bad++; end
            if (bus.loadb) begin t_b++; if (bus.nsel != 3'b100) t_bad++; end
            if (bus.loadc) t_c++;
            if (bus.loads) t_s++;
            if (bus.loadc || bus.loads) t_alu = bus.alu_op;
            if (bus.write) begin
                t_w++;
                t_vs = bus.vsel;
                if (bus.nsel != ((bus.vsel == 2'b10) ? 3'b001 : 3'b010)) t_bad++;
            end
            if (bus.asel) t_as++;
            if (bus.bsel || bus.vsel == 2'b01 || bus.vsel == 2'b11 || bus.halted) t_bad++;
            t_cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'b110, 2'b10, 3, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b10, "movi"};
        vecs[1] = '{3'b110, 2'b00, 4, 1, 0, 1, 1, 0, 1, 1, 2'b00, 2'b00, "movr"};
        vecs[2] = '{3'b101, 2'b11, 4, 1, 0, 1, 1, 0, 1, 0, 2'b11, 2'b00, "mvn"};
        vecs[3] = '{3'b101, 2'b00, 5, 1, 1, 1, 1, 0, 1, 0, 2'b00, 2'b00, "add"};
        vecs[4] = '{3'b101, 2'b01, 4, 1, 1, 1, 0, 1, 0, 0, 2'b01, 2'b00, "cmp"};
        vecs[5] = '{3'b101, 2'b10, 5, 1, 1, 1, 1, 0, 1, 0, 2'b10, 2'b00, "and"};
        vecs[6] = '{3'b000, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "ill000"};
        vecs[7] = '{3'b110, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "ill_mov01"};
        vecs[8] = '{3'b110, 2'b11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "ill_mov11"};
        vecs[9] = '{3'b011, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, "ill011"};
        bus.s = 1'b0;
        bus.opcode = 3'b000;
        bus.op = 2'b00;

        #2;
        check("rst_w", {31'd0, bus.w}, 1);
        check("rst_strobes", {25'd0, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.write, bus.asel, bus.bsel}, 0);
        check("rst_nsel", {29'd0, bus.nsel}, 0);
        check("rst_vsel_alu", {28'd0, bus.vsel, bus.alu_op}, 0);
        check("rst_cnt", {16'd0, bus.instr_cnt}, 0);
        check("rst_halted", {31'd0, bus.halted}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].opc, vecs[i].op, 1'b0);
            exp_cnt += vecs[i].inc;
            check({vecs[i].name, "_cycles"}, t_cyc, vecs[i].cyc);
            check({vecs[i].name, "_cnt"}, {16'd0, bus.instr_cnt}, exp_cnt);
            check({vecs[i].name, "_loada"}, t_a, vecs[i].na);
            check({vecs[i].name, "_loadb"}, t_b, vecs[i].nb);
            check({vecs[i].name, "_loadc"}, t_c, vecs[i].nc);
            check({vecs[i].name, "_loads"}, t_s, vecs[i].ns);
            check({vecs[i].name, "_write"}, t_w, vecs[i].nw);
            check({vecs[i].name, "_asel"}, t_as, vecs[i].nas);
            check({vecs[i].name, "_alu_op"}, {30'd0, t_alu}, {30'd0, vecs[i].alu});
            check({vecs[i].name, "_vsel"}, {30'd0, t_vs}, {30'd0, vecs[i].vs});
            check({vecs[i].name, "_nsel_bad"}, t_bad, 0);
        end

        // reset asserted while ADD is in GET_B
        bus.opcode = 3'b101;
        bus.op = 2'b00;
        bus.s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s = 1'b0;
        t_cyc = 0;
        while (!bus.loadb && t_cyc < 10) begin
            t_cyc++;
            @(negedge clk);
        end
        check("midrst_reached_getb", {31'd0, bus.loadb}, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_write", {31'd0, bus.write}, 0);
        check("midrst_loadb", {31'd0, bus.loadb}, 0);
        check("midrst_w", {31'd0, bus.w}, 1);
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
        #1;
        check("midrst_cnt", {16'd0, bus.instr_cnt}, exp_cnt);
        @(negedge clk);

        // s held high: illegal then MOVr back to back
        issue(3'b000, 2'b00, 1'b1);
        check("b2b_ill_cycles", t_cyc, 1);
        check("b2b_ill_cnt", {16'd0, bus.instr_cnt}, exp_cnt);
        issue(3'b110, 2'b00, 1'b1);
        bus.s = 1'b0;
        exp_cnt++;
        check("b2b_movr_cycles", t_cyc, 4);
        check("b2b_movr_asel", t_as, 1);
        check("b2b_movr_cnt", {16'd0, bus.instr_cnt}, exp_cnt);
        @(negedge clk);

`ifdef CTRL_HALT_EN
        bus.opcode = 3'b111;
        bus.op = 2'b00;
        bus.s = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        t_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.w && bus.halted && !(bus.loada | bus.loadb | bus.loadc | bus.loads | bus.write)) t_cyc++;
            @(negedge clk);
        end
        exp_cnt++;
        check("halt_hold_cycles", t_cyc, 20);
        check("halt_cnt", {16'd0, bus.instr_cnt}, exp_cnt);
        bus.s = 1'b0;
        reset = 1'b1;
        #1;
        check("halt_reset_exit", {30'd0, bus.halted, bus.w}, 1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
`else
        issue(3'b111, 2'b00, 1'b0);
        check("halt_off_cycles", t_cyc, 1);
        check("halt_off_bad", t_bad, 0);
        check("halt_off_halted", {31'd0, bus.halted}, 0);
        check("halt_off_cnt", {16'd0, bus.instr_cnt}, exp_cnt);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
